axi4_lite_master: RTL and testbench

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_pkg.sv | 21 ++
 rtl/axi4_lite_master.sv | 177 +++++++++++++++++
 tb/tb_axi4_lite_master.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types and default widths for the AXI4-Lite single-outstanding master.
package axi4_lite_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master bridging a simple cmd/rsp handshake to one outstanding AXI transaction.
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef AXIL_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  // command / response side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  // AXI4-Lite master
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic                    aw_done, w_done;
  logic                    cmd_accept;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                    timeout_hit;

  // The RDATA port shadows the imported state literal, so that state is always package-qualified.
  assign BREADY     = (state == WRESP);
  assign RREADY     = (state == axi4_lite_pkg::RDATA);
  assign rsp_valid  = (state == RESP);
  assign cmd_ready  = (state == IDLE) && !reset;
  assign cmd_accept = cmd_valid && (state == IDLE);

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID  && WREADY;
  assign b_hs  = BVALID  && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID  && RREADY;

  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign rsp_write = write_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nx = state;
    unique case (state)
      IDLE:  if (cmd_accept) state_nx = cmd_write ? WRITE : READ;
      WRITE: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WRESP;
      WRESP: if (b_hs) state_nx = RESP;
      READ:  if (ar_hs) state_nx = axi4_lite_pkg::RDATA;
      axi4_lite_pkg::RDATA: if (r_hs) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (timeout_hit) state_nx = RESP;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      ARVALID   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      if (cmd_accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        write_q <= cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end

      // First WRITE cycle launches both channels; afterwards each drops on its own handshake.
      if (state == WRITE) begin
        if (!AWVALID && !WVALID && !aw_done && !w_done) begin
          AWVALID <= 1'b1;
          WVALID  <= 1'b1;
        end else begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
        end
      end

      if (state == READ) begin
        if (!ARVALID)   ARVALID <= 1'b1;
        else if (ar_hs) ARVALID <= 1'b0;
      end

      if (b_hs) begin
        rsp_resp  <= BRESP;
        rsp_rdata <= '0;
      end
      if (r_hs) begin
        rsp_resp  <= RRESP;
        rsp_rdata <= RDATA;
      end

      // Abandoning a stalled transfer overrides everything above.
      if (timeout_hit) begin
        AWVALID   <= 1'b0;
        WVALID    <= 1'b0;
        ARVALID   <= 1'b0;
        rsp_resp  <= SLVERR;
        rsp_rdata <= '0;
      end
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_active;
  logic          any_hs;

  assign tmo_active  = state inside {WRITE, WRESP, READ, axi4_lite_pkg::RDATA};
  assign any_hs      = aw_hs || w_hs || b_hs || ar_hs || r_hs;
  assign timeout_hit = tmo_active && !any_hs && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles between AXI handshakes; any handshake shows the slave is alive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     tmo_cnt <= '0;
    else if (!tmo_active || any_hs) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed self-checking bench for axi4_lite_master; the timeout scenario runs when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axi4_lite_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  int n_checks = 0;
  int n_errors = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_rsp = 0;
  int cyc;

  logic [31:0] mem [bit [31:0]];
  logic [31:0] pend_addr, pend_data;
  bit          pend_a = 1'b0, pend_w = 1'b0;

  always #5 clk = ~clk;

  axi4_lite_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
`ifdef AXIL_MASTER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Slave-side observer: counts handshakes and stores completed writes.
  always @(posedge clk) begin
    if (!reset) begin
      if (AWVALID && AWREADY) begin n_aw++; pend_addr = AWADDR; pend_a = 1'b1; end
      if (WVALID && WREADY)   begin n_w++;  pend_data = WDATA;  pend_w = 1'b1; end
      if (pend_a && pend_w)   begin mem[pend_addr] = pend_data; pend_a = 1'b0; pend_w = 1'b0; end
      if (BVALID && BREADY)   n_b++;
      if (ARVALID && ARREADY) n_ar++;
      if (RVALID && RREADY)   n_r++;
      if (rsp_valid && rsp_ready) n_rsp++;
    end
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic wait_rsp(input string tag, input int budget, output int n);
    n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'h0, rsp_valid}, 64'h1);
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    slave_idle();
    repeat (3) @(negedge clk);
    check("rst_ctrl", {cmd_ready, AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
    check("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 0);
    check("rst_addr", {AWADDR, ARADDR}, 0);
    check("rst_wdata", WDATA, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", cmd_ready, 1);

    // T1: write, slave already ready, BVALID already high
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    issue(1'b1, 32'h8000_0004, 32'hDEAD_BEEF);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t1_busy", cmd_ready, 0);
    check("t1_bvalid_ignored", BREADY, 0);
    @(negedge clk);
    check("t1_aw_w_valid", {AWVALID, WVALID}, 2'b11);
    check("t1_awaddr", AWADDR, 32'h8000_0004);
    check("t1_wdata", WDATA, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_wresp", {AWVALID, WVALID, BREADY, rsp_valid}, 4'b0010);
    @(negedge clk);
    check("t1_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1100);
    check("t1_rdata_zero", rsp_rdata, 0);
    slave_idle();
    consume_rsp();
    check("t1_back_idle", {rsp_valid, cmd_ready}, 2'b01);
    check("t1_hs_count", {n_aw[7:0], n_w[7:0], n_b[7:0], n_rsp[7:0]}, 32'h0101_0101);
    check("t1_mem", mem_rd(32'h8000_0004), 32'hDEAD_BEEF);

    // T2: WREADY arrives 4 cycles after the AW handshake
    AWREADY = 1'b1;
    issue(1'b1, 32'h8000_0010, 32'h1234_5678);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t2_both_valid", {AWVALID, WVALID}, 2'b11);
    @(negedge clk);
    check("t2_aw_dropped", {AWVALID, WVALID}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      check("t2_w_held", {WVALID, AWVALID, BREADY}, 3'b100);
      check("t2_wdata_stable", WDATA, 32'h1234_5678);
      @(negedge clk);
    end
    check("t2_w_still", {WVALID, AWVALID}, 2'b10);
    WREADY = 1'b1;
    @(negedge clk);
    WREADY = 1'b0; AWREADY = 1'b0;
    check("t2_wresp", {AWVALID, WVALID, BREADY, rsp_valid}, 4'b0010);
    BVALID = 1'b1; BRESP = 2'b10;
    @(negedge clk);
    BVALID = 1'b0; BRESP = 2'b00;
    check("t2_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1110);
    consume_rsp();
    check("t2_hs_count", {n_aw[7:0], n_w[7:0], n_b[7:0], n_rsp[7:0]}, 32'h0202_0202);
    check("t2_mem", mem_rd(32'h8000_0010), 32'h1234_5678);

    // T3: read back the first write, ARREADY and RVALID already high
    ARREADY = 1'b1; RVALID = 1'b1; RRESP = 2'b00; RDATA = mem_rd(32'h8000_0004);
    issue(1'b0, 32'h8000_0004, 32'hFFFF_FFFF);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t3_rvalid_ignored", RREADY, 0);
    @(negedge clk);
    check("t3_arvalid", ARVALID, 1);
    check("t3_araddr", ARADDR, 32'h8000_0004);
    @(negedge clk);
    check("t3_rdata_state", {ARVALID, RREADY, rsp_valid}, 3'b010);
    @(negedge clk);
    slave_idle();
    check("t3_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1000);
    check("t3_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // T4: rsp_ready held low for 10 cycles while a new command waits
    issue(1'b1, 32'h8000_0020, 32'hA5A5_5A5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_cmd_blocked", cmd_ready, 0);
      check("t4_rsp_stable", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF});
    end
    consume_rsp();
    check("t4_idle_after_hs", {cmd_ready, rsp_valid}, 2'b10);
    check("t4_rsp_count", n_rsp, 3);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t4_next_accepted", cmd_ready, 0);
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    wait_rsp("t4_wr_rsp", 10, cyc);
    check("t4_latency", cyc, 3);
    check("t4_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1100);
    slave_idle();
    consume_rsp();
    check("t4_mem", mem_rd(32'h8000_0020), 32'hA5A5_5A5A);

    // T5: reset while waiting in RDATA
    ARREADY = 1'b1;
    issue(1'b0, 32'h8000_0020, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ARREADY = 1'b0;
    check("t5_in_rdata", {RREADY, ARVALID}, 2'b10);
    reset = 1'b1;
    #1;
    check("t5_rst_ctrl", {cmd_ready, AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 0);
    check("t5_rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 0);
    check("t5_rst_addr", {AWADDR, ARADDR}, 0);
    RVALID = 1'b1; RDATA = 32'h0BAD_F00D;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; RVALID = 1'b0; RDATA = 32'h0;
    #1;
    check("t5_ready_after_rst", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_rsp", {rsp_valid, RREADY}, 2'b00);
    end
    check("t5_rsp_count", n_rsp, 4);
    ARREADY = 1'b1; RVALID = 1'b1; RRESP = 2'b00; RDATA = mem_rd(32'h8000_0020);
    issue(1'b0, 32'h8000_0020, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("t5_rd_rsp", 10, cyc);
    check("t5_latency", cyc, 3);
    check("t5_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1000);
    check("t5_rdata", rsp_rdata, 32'hA5A5_5A5A);
    slave_idle();
    consume_rsp();
    check("t5_rsp_count_after", n_rsp, 5);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // T6: ARREADY never rises; the watchdog forces an SLVERR response
    issue(1'b0, 32'h8000_0040, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("t6_tmo_rsp", 40, cyc);
    check("t6_latency", cyc, 16);
    check("t6_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1010);
    check("t6_rdata", rsp_rdata, 0);
    check("t6_axi_quiet", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
    consume_rsp();
    check("t6_idle", cmd_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
